// File: rtl/dma_pkg.sv
// Shared state encoding, write-enable codes and address helper for the DMA controller.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitDev,
    StMem,
    StAck,
    StDone
  } dma_state_e;

  localparam logic [1:0] WeRead  = 2'b00;
  localparam logic [1:0] WeWrite = 2'b11;

  function automatic logic [14:0] byte_to_word(input logic [15:0] byte_addr);
    return byte_addr[15:1];
  endfunction

endpackage

// File: rtl/dma_addr_counter.sv
// Word-address and remaining-count register for one DMA transfer.
module dma_addr_counter
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [15:0] start_addr_i,
  input  logic [15:0] num_words_i,
  input  logic        step_i,
  output logic [14:0] addr_o,
  output logic [15:0] count_o,
  output logic        last_o
);

  logic [14:0] addr_q;
  logic [15:0] count_q;

  // Address wraps naturally at 15 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      addr_q  <= byte_to_word(start_addr_i);
      count_q <= num_words_i;
    end else if (step_i) begin
      addr_q  <= addr_q + 15'd1;
      count_q <= count_q - 16'd1;
    end
  end

  assign addr_o  = addr_q;
  assign count_o = count_q;
  assign last_o  = (count_q == 16'd1);

endmodule

// File: rtl/dma_controller.sv
// Single-channel word DMA between a handshaking device and a ready/response memory port.
module dma_controller
  import dma_pkg::*;
#(
  parameter logic DMA_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic [15:0] dev_out,
  input  logic        dev_ack,
  output logic [15:0] dev_in,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_error,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp
);

  dma_state_e  state_q, state_d;
  logic        dir_q;
  logic        abort_q;
  logic [15:0] dev_in_q, din_q;
  logic        error_q, en_q, ack_q, end_q, prio_q;
  logic [1:0]  we_q;
  logic        load, step, last;
  logic [15:0] count_unused;

  assign load = (state_q == StIdle) && dma_rqst;
  assign step = (state_q == StAck);

  dma_addr_counter u_addr_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (load),
    .start_addr_i (dma_start_address),
    .num_words_i  (dma_num_words),
    .step_i       (step),
    .addr_o       (dma_addr),
    .count_o      (count_unused),
    .last_o       (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (dma_rqst) state_d = (dma_num_words == 16'd0) ? StDone : StWaitDev;
      StWaitDev: begin
        if (!dma_rqst)   state_d = StIdle;
        else if (dev_ack) state_d = StMem;
      end
      // A started access always runs to dma_ready; an abort only redirects the exit.
      StMem: begin
        if (dma_ready) begin
          if (abort_q || !dma_rqst) state_d = StIdle;
          else if (dma_resp)        state_d = StDone;
          else                      state_d = StAck;
        end
      end
      StAck:     state_d = last ? StDone : StWaitDev;
      StDone:    if (!dma_rqst) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      abort_q  <= 1'b0;
      dev_in_q <= '0;
      din_q    <= '0;
      error_q  <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= WeRead;
      prio_q   <= 1'b0;
      ack_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= (state_q == StMem) ? (abort_q | ~dma_rqst) : 1'b0;
      if (load) begin
        dir_q   <= dma_rd_wr;
        error_q <= 1'b0;
      end
      if ((state_q == StWaitDev) && dma_rqst && dev_ack) din_q <= dev_out;
      if ((state_q == StMem) && dma_ready) begin
        if (dma_resp)   error_q  <= 1'b1;
        else if (dir_q) dev_in_q <= dma_dout;
      end
      // Outputs are registered from the next state so they align with it.
      en_q   <= (state_d == StMem);
      we_q   <= ((state_d == StMem) && !dir_q) ? WeWrite : WeRead;
      prio_q <= (state_d == StMem) ? DMA_PRIORITY : 1'b0;
      ack_q  <= (state_d == StAck);
      end_q  <= (state_d == StDone);
    end
  end

  assign dev_in       = dev_in_q;
  assign dma_din      = din_q;
  assign dma_error    = error_q;
  assign dma_en       = en_q;
  assign dma_we       = we_q;
  assign dma_priority = prio_q;
  assign dma_ack      = ack_q;
  assign dma_end_flag = end_q;

endmodule
